// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Force a byte PC onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] p);
    return {p[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the instruction memory and holds
// one fetched instruction in a valid/ready output stage toward decode.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic         fire;
  logic         load;

  assign fire = fetch_valid && fetch_ready;
  // Redirect wins over a load: the flushed cycle never captures the old path.
  assign load = (state == RUN) && !halt_req && !redirect_valid &&
                (!fetch_valid || fetch_ready);

  // Word address; the low ADDR_W bits form the index the memory decodes, so
  // wrap past the last word falls out of the memory ignoring the upper field.
  assign imem_addr = {2'b00, pc[31:ADDR_W+2], pc[ADDR_W+1:2]};
  assign halted    = (state == IDLE) || (state == HALTED);

  // Next-state: drain waits for the output stage to empty before halting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!halt_req)                 state_nxt = RUN;
        else if (!fetch_valid || fire) state_nxt = HALTED;
      end
      HALTED:  if (start && !halt_req) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // PC: redirect target (any state) or sequential advance on each load.
  always_ff @(posedge clk) begin
    if (reset)               pc <= RESET_PC;
    else if (redirect_valid) pc <= align_pc(redirect_pc);
    else if (load)           pc <= pc + PC_STEP;
  end

  // Output stage: flush on redirect, capture on load, empty on a bare fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_instr <= INSTR_NOP;
      fetch_pc    <= 32'h0;
    end else if (redirect_valid) begin
      fetch_valid <= 1'b0;
    end else if (load) begin
      fetch_valid <= 1'b1;
      fetch_instr <= imem_rdata;
      fetch_pc    <= pc;
    end else if (fire) begin
      fetch_valid <= 1'b0;
    end
  end

  // Status: sticky misalignment flag and retired-fetch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
      fetch_count  <= 32'h0;
    end else begin
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
      if (fire) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vectors, a cycle model of the fetch
// behaviour compared on every cycle, plus literal spot checks.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];
  assign imem_rdata = mem[imem_addr[5:0]];

  imem_fetch_ctrl #(.RESET_PC(32'h0), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .halted(halted),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 draining, 3 halted
  int          m_mode;
  logic [31:0] m_pc, m_count, m_instr, m_fpc;
  bit          m_has, m_mis, m_en;
  bit          m_fire, m_had;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_pc = 32'h0; m_has = 0; m_instr = NOP; m_fpc = 0;
      m_mis = 0; m_count = 0; m_en = 1;
    end else if (m_en) begin
      m_had  = m_has;
      m_fire = m_has && fetch_ready;
      if (m_fire) m_count = m_count + 1;
      if (redirect_valid) begin
        m_has = 0;
        if (redirect_pc % 4 != 0) m_mis = 1;
        m_pc = redirect_pc - (redirect_pc % 4);
      end else if (m_mode == 1 && !halt_req && (!m_has || fetch_ready)) begin
        m_instr = mem[(m_pc / 4) % 64];
        m_fpc   = m_pc;
        m_has   = 1;
        m_pc    = m_pc + 4;
      end else if (m_fire) begin
        m_has = 0;
      end
      case (m_mode)
        0: if (start) m_mode = 1;
        1: if (halt_req) m_mode = 2;
        2: if (!halt_req) m_mode = 1;
           else if (!m_had || m_fire) m_mode = 3;
        default: if (start && !halt_req) m_mode = 1;
      endcase
    end
  end

  // Per-cycle compare on the falling edge.
  initial forever begin
    @(negedge clk);
    if (m_en) begin
      check("valid", {31'b0, fetch_valid}, {31'b0, m_has});
      if (m_has) begin
        check("instr", fetch_instr, m_instr);
        check("pc_out", fetch_pc, m_fpc);
      end
      check("addr", imem_addr, m_pc / 4);
      check("halted", {31'b0, halted}, {31'b0, (m_mode == 0 || m_mode == 3)});
      check("misalign", {31'b0, misalign_err}, {31'b0, m_mis});
      check("count", fetch_count, m_count);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;

    // T1: reset, start, free-flowing decode
    step(2);
    check("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_instr", fetch_instr, 32'h0000_0013);
    check("rst_pc", fetch_pc, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd1);
    check("rst_count", fetch_count, 32'h0);
    reset = 0; start = 1; fetch_ready = 1;
    step(1);
    start = 0;
    check("t1_cyc1_valid", {31'b0, fetch_valid}, 32'd0);
    step(1);
    check("t1_A_instr", fetch_instr, 32'hC0DE_0000);
    check("t1_A_pc", fetch_pc, 32'h0);
    step(1);
    check("t1_B_pc", fetch_pc, 32'h4);

    // T2: decode stalls with B held
    fetch_ready = 0;
    step(3);
    check("t2_B_instr", fetch_instr, 32'hC0DE_0001);
    check("t2_B_pc", fetch_pc, 32'h4);
    check("t2_addr", imem_addr, 32'h2);
    check("t2_count", fetch_count, 32'd1);

    // T4: halt while B held, then drain and resume
    halt_req = 1;
    step(1);
    check("t4_drain_halted", {31'b0, halted}, 32'd0);
    fetch_ready = 1;
    step(1);
    check("t4_halted", {31'b0, halted}, 32'd1);
    check("t4_count", fetch_count, 32'd2);
    step(2);
    check("t4_no_load", {31'b0, fetch_valid}, 32'd0);
    halt_req = 0; start = 1;
    step(1);
    start = 0;
    step(1);
    check("t4_resume_pc", fetch_pc, 32'h8);
    check("t4_resume_instr", fetch_instr, 32'hC0DE_0002);

    // T3: redirect coinciding with a fired handshake on C
    redirect_valid = 1; redirect_pc = 32'h20;
    step(1);
    redirect_valid = 0;
    check("t3_flush", {31'b0, fetch_valid}, 32'd0);
    check("t3_count", fetch_count, 32'd3);
    step(1);
    check("t3_target_pc", fetch_pc, 32'h20);
    check("t3_target_instr", fetch_instr, 32'hC0DE_0008);

    // T5: misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h0000_0006;
    step(1);
    redirect_valid = 0;
    check("t5_misalign", {31'b0, misalign_err}, 32'd1);
    step(1);
    check("t5_pc", fetch_pc, 32'h4);
    step(3);
    check("t5_sticky", {31'b0, misalign_err}, 32'd1);

    // T6: wrap at the last memory word, then reset mid-run
    redirect_valid = 1; redirect_pc = 32'hFC;
    step(1);
    redirect_valid = 0;
    step(1);
    check("t6_w63_pc", fetch_pc, 32'hFC);
    check("t6_w63_instr", fetch_instr, 32'hC0DE_003F);
    check("t6_addr_low", {26'b0, imem_addr[5:0]}, 32'h0);
    step(1);
    check("t6_wrap_pc", fetch_pc, 32'h100);
    check("t6_wrap_instr", fetch_instr, 32'hC0DE_0000);
    reset = 1;
    step(1);
    check("t6_rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("t6_rst_count", fetch_count, 32'h0);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_halted", {31'b0, halted}, 32'd1);
    reset = 0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
